ram_loader: RTL

// Write-side counterpart to the ROM image store. Accepts a byte stream over a valid/ready

---
 rtl/ram_loader.sv | 82 ++++++++
 1 files changed

// File: rtl/ram_loader.sv
// ram_loader: packs a valid/ready byte stream little-endian into words written to a RAM with async read
module ram_loader #(
  parameter int SIZE = 256,
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = $clog2(SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 flush,
  input  logic [7:0]           in_byte,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [ADDR_BITS:0]   word_count,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);
  localparam int BPW = DATA_BITS / 8;
  localparam int IB = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [IB-1:0] bidx;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [DATA_BITS-1:0] stage, nxt;
  logic [DATA_BITS-1:0] mem [SIZE];
  logic acc, last, wr, full;
  assign in_ready = state == LOAD;
  assign busy = state == LOAD;
  assign done = state == DONE;
  // stage keeps unfilled upper bytes zero, so OR-ing in the new byte also zero-pads partial words
  always_comb begin
    acc = in_valid && state == LOAD;
    last = acc && bidx == IB'(BPW - 1);
    nxt = acc ? stage | (DATA_BITS'(in_byte) << {bidx, 3'b000}) : stage;
    wr = !rst && !start && state == LOAD && (last || (flush && (acc || bidx != '0)));
    full = word_count == (ADDR_BITS + 1)'(SIZE - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      overflow <= 1'b0;
      word_count <= '0;
      wr_addr <= '0;
      bidx <= '0;
      stage <= '0;
    end else if (start) begin
      state <= LOAD;
      overflow <= 1'b0;
      word_count <= '0;
      wr_addr <= '0;
      bidx <= '0;
      stage <= '0;
    end else if (state == LOAD) begin
      if (acc) begin
        bidx <= last ? '0 : bidx + 1'b1;
        stage <= last ? '0 : nxt;
      end
      if (wr) begin
        word_count <= word_count + 1'b1;
        wr_addr <= wr_addr + 1'b1;
        bidx <= '0;
        stage <= '0;
      end
      if (flush || (wr && full)) state <= DONE;
    end else if (state == DONE && in_valid) begin
      overflow <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wr_addr] <= nxt;
  end
  generate
    if (SIZE == (1 << ADDR_BITS)) begin : g_full
      assign rd_data = mem[rd_addr];
    end else begin : g_part
      assign rd_data = (32'(rd_addr) < SIZE) ? mem[rd_addr] : '0;
    end
  endgenerate
endmodule
